// File: rtl/mdu_sequencer_pkg.sv
// -----------------------------------------------------------------------------
// mdu_sequencer_pkg
// Shared definitions for the iterative multiply/divide unit.
//   - mdu_op_e    : request op codes (MUL, MULU, DIV, DIVU)
//   - mdu_state_e : sequencer FSM state encodings
//   - op_is_div / op_is_signed : op-code classification helpers
// No ports (package).
// -----------------------------------------------------------------------------
package mdu_sequencer_pkg;

   typedef enum logic [1:0] {
      OP_MUL  = 2'b00,
      OP_MULU = 2'b01,
      OP_DIV  = 2'b10,
      OP_DIVU = 2'b11
   } mdu_op_e;

   typedef enum logic [1:0] {
      ST_IDLE = 2'b00,
      ST_CALC = 2'b01,
      ST_FIX  = 2'b10,
      ST_DONE = 2'b11
   } mdu_state_e;

   function automatic logic op_is_div(input mdu_op_e op);
      return (op == OP_DIV) || (op == OP_DIVU);
   endfunction

   function automatic logic op_is_signed(input mdu_op_e op);
      return (op == OP_MUL) || (op == OP_DIV);
   endfunction

endpackage

// File: rtl/mdu_sequencer_if.sv
// -----------------------------------------------------------------------------
// mdu_sequencer_if
// Request/result handshake bundle between the EX stage and the MDU.
//   req_valid/req_ready/req_op/req_a/req_b : request channel
//   flush                                  : abort in-flight operation
//   res_valid/res_ready/res_hi/res_lo      : result channel
//   busy                                   : pipeline stall request
// Modports: master (pipeline side), slave (MDU side).
// -----------------------------------------------------------------------------
interface mdu_sequencer_if #(
   parameter int XLEN = 32
);
   logic            req_valid;
   logic            req_ready;
   logic [1:0]      req_op;
   logic [XLEN-1:0] req_a;
   logic [XLEN-1:0] req_b;
   logic            flush;
   logic            res_valid;
   logic            res_ready;
   logic [XLEN-1:0] res_hi;
   logic [XLEN-1:0] res_lo;
   logic            busy;

   modport master (
      output req_valid, req_op, req_a, req_b, flush, res_ready,
      input  req_ready, res_valid, res_hi, res_lo, busy
   );

   modport slave (
      input  req_valid, req_op, req_a, req_b, flush, res_ready,
      output req_ready, res_valid, res_hi, res_lo, busy
   );
endinterface

// File: rtl/mdu_sequencer_iter_step.sv
// -----------------------------------------------------------------------------
// mdu_sequencer_iter_step
// Combinational single iteration of the MDU datapath.
//   MUL: conditional add of the multiplicand, then {acc,mplr} >> 1.
//   DIV: {rem,quo} << 1, trial-subtract divisor, restore on negative.
// Ports:
//   is_div_i : 1 = restoring-divide step, 0 = shift-add step
//   acc_i    : accumulator (MUL) / partial remainder (DIV)
//   lo_i     : multiplier (MUL) / dividend-quotient (DIV)
//   opnd_i   : multiplicand (MUL) / divisor (DIV)
//   acc_o, lo_o : updated acc / lo after one step
// -----------------------------------------------------------------------------
module mdu_sequencer_iter_step #(
   parameter int XLEN = 32
) (
   input  logic            is_div_i,
   input  logic [XLEN-1:0] acc_i,
   input  logic [XLEN-1:0] lo_i,
   input  logic [XLEN-1:0] opnd_i,
   output logic [XLEN-1:0] acc_o,
   output logic [XLEN-1:0] lo_o
);
   // XLEN+1 bits: carry out of the add, borrow of the trial subtract
   logic [XLEN:0] sum_s;
   logic [XLEN:0] shifted_s;
   logic [XLEN:0] diff_s;

   // One shift-add or restoring-divide iteration
   always_comb begin
      acc_o     = acc_i;
      lo_o      = lo_i;
      sum_s     = {1'b0, acc_i} + (lo_i[0] ? {1'b0, opnd_i} : {(XLEN+1){1'b0}});
      shifted_s = {acc_i, lo_i[XLEN-1]};
      diff_s    = shifted_s - {1'b0, opnd_i};
      if (is_div_i) begin
         // Restore path only when shifted < divisor, so its top bit is zero
         if (!diff_s[XLEN]) begin
            acc_o = diff_s[XLEN-1:0];
            lo_o  = {lo_i[XLEN-2:0], 1'b1};
         end else begin
            acc_o = shifted_s[XLEN-1:0];
            lo_o  = {lo_i[XLEN-2:0], 1'b0};
         end
      end else begin
         acc_o = sum_s[XLEN:1];
         lo_o  = {sum_s[0], lo_i[XLEN-1:1]};
      end
   end
endmodule

// File: rtl/mdu_sequencer.sv
// -----------------------------------------------------------------------------
// mdu_sequencer
// Iterative multiply/divide unit beside the EX-stage ALU. Accepts one
// MUL/MULU/DIV/DIVU per handshake, runs XLEN iterations on magnitudes,
// applies signs, and presents {hi,lo} under valid/ready.
// Ports:
//   clk   : clock, rising edge
//   rst_n : asynchronous active-low reset
//   bus   : mdu_sequencer_if.slave (request, flush, result, busy)
// Optional build macro:
//   MDU_DIV0_FAST_EN : divide by zero goes IDLE->DONE directly (1-cycle
//                      latency); result values are unchanged.
// -----------------------------------------------------------------------------
module mdu_sequencer
   import mdu_sequencer_pkg::*;
#(
   parameter int XLEN = 32
) (
   input logic            clk,
   input logic            rst_n,
   mdu_sequencer_if.slave bus
);
   localparam int CW = $clog2(XLEN) + 1;

   function automatic logic [XLEN-1:0] neg_x(input logic [XLEN-1:0] v);
      return ~v + {{(XLEN-1){1'b0}}, 1'b1};
   endfunction

   function automatic logic [2*XLEN-1:0] neg_2x(input logic [2*XLEN-1:0] v);
      return ~v + {{(2*XLEN-1){1'b0}}, 1'b1};
   endfunction

   mdu_state_e      state_q, state_d, next_st_s;
   mdu_op_e         op_q, op_d, op_in_s;
   logic [XLEN-1:0] acc_q, acc_d, lo_q, lo_d, opnd_q, opnd_d;
   logic [XLEN-1:0] a_raw_q, a_raw_d;
   logic            sa_q, sa_d, sb_q, sb_d, div0_q, div0_d;
   logic [CW-1:0]   cnt_q, cnt_d;
   logic            req_ready_q, req_ready_d;
   logic            res_valid_q, res_valid_d;
   logic            busy_q, busy_d;
   logic [XLEN-1:0] res_hi_q, res_hi_d, res_lo_q, res_lo_d;

   logic            is_div_s, a_neg_s, b_neg_s, div0_in_s;
   logic [XLEN-1:0] step_acc_s, step_lo_s, fix_hi_s, fix_lo_s;
   logic [2*XLEN-1:0] prod_s;

   assign op_in_s   = mdu_op_e'(bus.req_op);
   assign is_div_s  = op_is_div(op_q);
   assign a_neg_s   = op_is_signed(op_in_s) && bus.req_a[XLEN-1];
   assign b_neg_s   = op_is_signed(op_in_s) && bus.req_b[XLEN-1];
   assign div0_in_s = op_is_div(op_in_s) && (bus.req_b == {XLEN{1'b0}});

   mdu_sequencer_iter_step #(.XLEN(XLEN)) u_step (
      .is_div_i (is_div_s),
      .acc_i    (acc_q),
      .lo_i     (lo_q),
      .opnd_i   (opnd_q),
      .acc_o    (step_acc_s),
      .lo_o     (step_lo_s)
   );

   // Sign correction of the magnitude result; div-by-zero returns the raw dividend
   always_comb begin
      prod_s   = {acc_q, lo_q};
      fix_hi_s = acc_q;
      fix_lo_s = lo_q;
      if (is_div_s) begin
         if (div0_q) begin
            fix_hi_s = a_raw_q;
            fix_lo_s = {XLEN{1'b1}};
         end else begin
            fix_lo_s = (sa_q ^ sb_q) ? neg_x(lo_q) : lo_q;
            fix_hi_s = sa_q ? neg_x(acc_q) : acc_q;
         end
      end else begin
         if (sa_q ^ sb_q) begin
            prod_s = neg_2x({acc_q, lo_q});
         end else begin
            prod_s = {acc_q, lo_q};
         end
         fix_hi_s = prod_s[2*XLEN-1:XLEN];
         fix_lo_s = prod_s[XLEN-1:0];
      end
   end

   // FSM next-state and datapath next-values; flush overrides every transition
   always_comb begin
      next_st_s = state_q;
      op_d      = op_q;
      acc_d     = acc_q;
      lo_d      = lo_q;
      opnd_d    = opnd_q;
      a_raw_d   = a_raw_q;
      sa_d      = sa_q;
      sb_d      = sb_q;
      div0_d    = div0_q;
      cnt_d     = cnt_q;
      res_hi_d  = res_hi_q;
      res_lo_d  = res_lo_q;
      case (state_q)
         ST_IDLE: begin
            if (bus.req_valid && req_ready_q && !bus.flush) begin
               op_d    = op_in_s;
               sa_d    = a_neg_s;
               sb_d    = b_neg_s;
               a_raw_d = bus.req_a;
               div0_d  = div0_in_s;
               acc_d   = {XLEN{1'b0}};
               lo_d    = a_neg_s ? neg_x(bus.req_a) : bus.req_a;
               opnd_d  = b_neg_s ? neg_x(bus.req_b) : bus.req_b;
               cnt_d   = {CW{1'b0}};
`ifdef MDU_DIV0_FAST_EN
               if (div0_in_s) begin
                  next_st_s = ST_DONE;
                  res_hi_d  = bus.req_a;
                  res_lo_d  = {XLEN{1'b1}};
               end else begin
                  next_st_s = ST_CALC;
               end
`else
               next_st_s = ST_CALC;
`endif
            end else begin
               next_st_s = ST_IDLE;
            end
         end
         ST_CALC: begin
            acc_d = step_acc_s;
            lo_d  = step_lo_s;
            cnt_d = cnt_q + CW'(1);
            // Last iteration when the count is about to reach XLEN
            if (cnt_q == CW'(XLEN - 1)) begin
               next_st_s = ST_FIX;
            end else begin
               next_st_s = ST_CALC;
            end
         end
         ST_FIX: begin
            // A flush here discards the result, leaving the previous one visible
            if (!bus.flush) begin
               res_hi_d = fix_hi_s;
               res_lo_d = fix_lo_s;
            end else begin
               res_hi_d = res_hi_q;
               res_lo_d = res_lo_q;
            end
            next_st_s = ST_DONE;
         end
         ST_DONE: begin
            if (bus.res_ready) begin
               next_st_s = ST_IDLE;
            end else begin
               next_st_s = ST_DONE;
            end
         end
         default: begin
            next_st_s = ST_IDLE;
         end
      endcase
      state_d     = bus.flush ? ST_IDLE : next_st_s;
      req_ready_d = (state_d == ST_IDLE);
      busy_d      = (state_d != ST_IDLE);
      res_valid_d = (state_d == ST_DONE);
   end

   // State, datapath and registered outputs
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= ST_IDLE;
         op_q        <= OP_MUL;
         acc_q       <= {XLEN{1'b0}};
         lo_q        <= {XLEN{1'b0}};
         opnd_q      <= {XLEN{1'b0}};
         a_raw_q     <= {XLEN{1'b0}};
         sa_q        <= 1'b0;
         sb_q        <= 1'b0;
         div0_q      <= 1'b0;
         cnt_q       <= {CW{1'b0}};
         req_ready_q <= 1'b1;
         res_valid_q <= 1'b0;
         busy_q      <= 1'b0;
         res_hi_q    <= {XLEN{1'b0}};
         res_lo_q    <= {XLEN{1'b0}};
      end else begin
         state_q     <= state_d;
         op_q        <= op_d;
         acc_q       <= acc_d;
         lo_q        <= lo_d;
         opnd_q      <= opnd_d;
         a_raw_q     <= a_raw_d;
         sa_q        <= sa_d;
         sb_q        <= sb_d;
         div0_q      <= div0_d;
         cnt_q       <= cnt_d;
         req_ready_q <= req_ready_d;
         res_valid_q <= res_valid_d;
         busy_q      <= busy_d;
         res_hi_q    <= res_hi_d;
         res_lo_q    <= res_lo_d;
      end
   end

   assign bus.req_ready = req_ready_q;
   assign bus.res_valid = res_valid_q;
   assign bus.busy      = busy_q;
   assign bus.res_hi    = res_hi_q;
   assign bus.res_lo    = res_lo_q;

endmodule

// File: tb/tb_mdu_sequencer.sv
// -----------------------------------------------------------------------------
// tb_mdu_sequencer
// Self-checking bench for mdu_sequencer: directed vector table, handshake and
// flush/reset corner sequences, and randomized operations compared against a
// plain-arithmetic reference model.
// -----------------------------------------------------------------------------
module tb_mdu_sequencer;
   import mdu_sequencer_pkg::*;

   logic clk;
   logic rst_n;
   int   n_cmp;
   int   n_fail;

   mdu_sequencer_if #(.XLEN(32)) bus ();

   mdu_sequencer #(.XLEN(32)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [1:0]  op;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] hi;
      logic [31:0] lo;
   } vec_t;

   vec_t vecs [12];

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Reference: {hi,lo} from plain signed/unsigned arithmetic
   function automatic logic [63:0] model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
      longint      p;
      logic [63:0] pu;
      int          qa;
      int          qb;
      case (op)
         2'b00: begin
            p = longint'($signed(a)) * longint'($signed(b));
            return p;
         end
         2'b01: begin
            pu = {32'd0, a} * {32'd0, b};
            return pu;
         end
         2'b10: begin
            if (b == 32'd0) return {a, 32'hFFFF_FFFF};
            if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {32'h0, 32'h8000_0000};
            qa = $signed(a);
            qb = $signed(b);
            return {32'(qa % qb), 32'(qa / qb)};
         end
         default: begin
            if (b == 32'd0) return {a, 32'hFFFF_FFFF};
            return {a % b, a / b};
         end
      endcase
   endfunction

   function automatic int exp_lat(input logic [1:0] op, input logic [31:0] b);
`ifdef MDU_DIV0_FAST_EN
      if (op[1] && b == 32'd0) return 1;
`endif
      return 34;
   endfunction

   // Issue one request, wait (bounded) for the result, then complete the handshake.
   // Entered and left on a negative edge with the unit idle.
   task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                         output logic [31:0] hi, output logic [31:0] lo, output int lat);
      bus.req_valid = 1'b1;
      bus.req_op    = op;
      bus.req_a     = a;
      bus.req_b     = b;
      @(posedge clk);
      @(negedge clk);
      bus.req_valid = 1'b0;
      lat = 1;
      while (!bus.res_valid && lat < 100) begin
         @(negedge clk);
         lat++;
      end
      hi = bus.res_hi;
      lo = bus.res_lo;
      bus.res_ready = 1'b1;
      @(negedge clk);
      bus.res_ready = 1'b0;
   endtask

   initial begin
      logic [31:0] hi;
      logic [31:0] lo;
      logic [63:0] exp;
      logic [1:0]  op;
      logic [31:0] a;
      logic [31:0] b;
      int          lat;
      int          bad;
      int          seen;

      n_cmp  = 0;
      n_fail = 0;
      bus.req_valid = 1'b0;
      bus.req_op    = 2'b00;
      bus.req_a     = 32'd0;
      bus.req_b     = 32'd0;
      bus.flush     = 1'b0;
      bus.res_ready = 1'b0;
      rst_n = 1'b1;
      #2 rst_n = 1'b0;

      vecs[0]  = '{2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001};
      vecs[1]  = '{2'b00, 32'hFFFF_FFF9, 32'h0000_0003, 32'hFFFF_FFFF, 32'hFFFF_FFEB};
      vecs[2]  = '{2'b10, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFD};
      vecs[3]  = '{2'b11, 32'd100,       32'd7,         32'd2,         32'd14};
      vecs[4]  = '{2'b10, 32'd5,         32'd0,         32'd5,         32'hFFFF_FFFF};
      vecs[5]  = '{2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0,         32'h8000_0000};
      vecs[6]  = '{2'b01, 32'd3,         32'd4,         32'd0,         32'd12};
      vecs[7]  = '{2'b10, 32'd7,         32'hFFFF_FFFE, 32'd1,         32'hFFFF_FFFD};
      vecs[8]  = '{2'b10, 32'hFFFF_FFF9, 32'd0,         32'hFFFF_FFF9, 32'hFFFF_FFFF};
      vecs[9]  = '{2'b00, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0};
      vecs[10] = '{2'b11, 32'hFFFF_FFFF, 32'd1,         32'd0,         32'hFFFF_FFFF};
      vecs[11] = '{2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0,         32'd1};

      repeat (3) @(negedge clk);
      check("rst_req_ready", 64'(bus.req_ready), 64'd1);
      check("rst_res_valid", 64'(bus.res_valid), 64'd0);
      check("rst_busy",      64'(bus.busy),      64'd0);
      check("rst_res_hi",    64'(bus.res_hi),    64'd0);
      check("rst_res_lo",    64'(bus.res_lo),    64'd0);
      rst_n = 1'b1;
      @(negedge clk);

      // Directed vector table
      for (int i = 0; i < 12; i++) begin
         check($sformatf("vec%0d_req_ready", i), 64'(bus.req_ready), 64'd1);
         run_op(vecs[i].op, vecs[i].a, vecs[i].b, hi, lo, lat);
         check($sformatf("vec%0d_hi", i),  64'(hi),  64'(vecs[i].hi));
         check($sformatf("vec%0d_lo", i),  64'(lo),  64'(vecs[i].lo));
         check($sformatf("vec%0d_lat", i), 64'(lat), 64'(exp_lat(vecs[i].op, vecs[i].b)));
      end

      // Result held while the consumer stalls
      bus.req_valid = 1'b1;
      bus.req_op    = 2'b11;
      bus.req_a     = 32'd100;
      bus.req_b     = 32'd7;
      @(posedge clk);
      @(negedge clk);
      bus.req_valid = 1'b0;
      lat = 1;
      while (!bus.res_valid && lat < 100) begin
         @(negedge clk);
         lat++;
      end
      check("hold_lat", 64'(lat), 64'd34);
      bad = 0;
      for (int k = 0; k < 5; k++) begin
         if (!(bus.res_valid && bus.busy && !bus.req_ready &&
               bus.res_lo == 32'd14 && bus.res_hi == 32'd2)) bad++;
         @(negedge clk);
      end
      check("hold_stable", 64'(bad), 64'd0);
      bus.res_ready = 1'b1;
      @(negedge clk);
      bus.res_ready = 1'b0;
      check("post_hs_valid", 64'(bus.res_valid), 64'd0);
      check("post_hs_ready", 64'(bus.req_ready), 64'd1);
      check("post_hs_busy",  64'(bus.busy),      64'd0);
      check("post_hs_lo",    64'(bus.res_lo),    64'd14);

      // Back-to-back: overflow divide, then MULU issued the cycle after handshake
      run_op(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, hi, lo, lat);
      check("b2b_div_lo", 64'(lo), 64'h8000_0000);
      check("b2b_div_hi", 64'(hi), 64'h0);
      check("b2b_ready",  64'(bus.req_ready), 64'd1);
      run_op(2'b01, 32'd3, 32'd4, hi, lo, lat);
      check("b2b_mul_lo",  64'(lo),  64'd12);
      check("b2b_mul_lat", 64'(lat), 64'd34);

      // Flush at cycle 10 of a DIVU
      bus.req_valid = 1'b1;
      bus.req_op    = 2'b11;
      bus.req_a     = 32'd1000;
      bus.req_b     = 32'd3;
      @(posedge clk);
      @(negedge clk);
      bus.req_valid = 1'b0;
      repeat (9) @(negedge clk);
      bus.flush = 1'b1;
      @(negedge clk);
      bus.flush = 1'b0;
      check("flush_busy",  64'(bus.busy),      64'd0);
      check("flush_ready", 64'(bus.req_ready), 64'd1);
      check("flush_valid", 64'(bus.res_valid), 64'd0);

      // Flush in the accept cycle drops the request
      bus.req_valid = 1'b1;
      bus.flush     = 1'b1;
      @(negedge clk);
      bus.req_valid = 1'b0;
      bus.flush     = 1'b0;
      check("flush_acc_busy", 64'(bus.busy), 64'd0);
      seen = 0;
      for (int k = 0; k < 40; k++) begin
         if (bus.res_valid) seen++;
         @(negedge clk);
      end
      check("flush_no_result", 64'(seen), 64'd0);

      // Flush wins over res_ready in DONE
      bus.req_valid = 1'b1;
      bus.req_op    = 2'b01;
      bus.req_a     = 32'd5;
      bus.req_b     = 32'd6;
      @(posedge clk);
      @(negedge clk);
      bus.req_valid = 1'b0;
      lat = 1;
      while (!bus.res_valid && lat < 100) begin
         @(negedge clk);
         lat++;
      end
      check("flush_done_lo", 64'(bus.res_lo), 64'd30);
      bus.flush     = 1'b1;
      bus.res_ready = 1'b1;
      @(negedge clk);
      bus.flush     = 1'b0;
      bus.res_ready = 1'b0;
      check("flush_done_valid", 64'(bus.res_valid), 64'd0);
      check("flush_done_ready", 64'(bus.req_ready), 64'd1);
      run_op(2'b01, 32'd2, 32'd2, hi, lo, lat);
      check("after_flush_lo", 64'(lo), 64'd4);

      // Randomized operations against the reference model
      for (int i = 0; i < 40; i++) begin
         op = 2'($urandom_range(0, 3));
         a  = $urandom;
         b  = $urandom;
         case ($urandom_range(0, 7))
            0: b = 32'd0;
            1: b = 32'($urandom_range(1, 15));
            2: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
            3: a = 32'($urandom_range(0, 99));
            default: ;
         endcase
         exp = model(op, a, b);
         run_op(op, a, b, hi, lo, lat);
         check($sformatf("rnd%0d_op%0d_hi", i, op), 64'(hi), 64'(exp[63:32]));
         check($sformatf("rnd%0d_op%0d_lo", i, op), 64'(lo), 64'(exp[31:0]));
         check($sformatf("rnd%0d_lat", i), 64'(lat), 64'(exp_lat(op, b)));
      end

      // Asynchronous reset at cycle 20 of a MUL
      bus.req_valid = 1'b1;
      bus.req_op    = 2'b00;
      bus.req_a     = 32'd123;
      bus.req_b     = 32'd456;
      @(posedge clk);
      @(negedge clk);
      bus.req_valid = 1'b0;
      repeat (19) @(negedge clk);
      rst_n = 1'b0;
      #1;
      check("midrst_req_ready", 64'(bus.req_ready), 64'd1);
      check("midrst_busy",      64'(bus.busy),      64'd0);
      check("midrst_valid",     64'(bus.res_valid), 64'd0);
      check("midrst_hi",        64'(bus.res_hi),    64'd0);
      check("midrst_lo",        64'(bus.res_lo),    64'd0);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      run_op(2'b00, 32'd123, 32'd456, hi, lo, lat);
      check("post_rst_lo", 64'(lo), 64'd56088);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end
endmodule
